// File: rtl/b01_serial_tx.sv
// b01 serial transmit side: shifts operand pairs out LSB-first on line1/line2
// and gathers the core's outp/overflw responses into a parallel result word.
module b01_serial_tx #(
  parameter int WIDTH  = 8,
  parameter int RX_LAT = 1,
  parameter int GAP    = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             line1,
  output logic             line2,
  input  logic             rx_outp,
  input  logic             rx_overflw,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ovf,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + RX_LAT + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  localparam logic [CW-1:0] W_C   = CW'(WIDTH);
  localparam logic [CW-1:0] L_C   = CW'(RX_LAT);
  localparam logic [CW-1:0] END_C = CW'(WIDTH + RX_LAT);
  localparam logic [GW-1:0] G_C   = GW'(GAP);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    GAP_S
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             line1_q, line1_d;
  logic             line2_q, line2_d;
  logic [WIDTH-1:0] stage_q, stage_d;
  logic             stg_ovf_q, stg_ovf_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ovf_q, res_ovf_d;
  logic             samp;

  // cnt_q holds the edge index relative to the accepting edge
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gcnt_d      = gcnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    line1_d     = 1'b0;
    line2_d     = 1'b0;
    stage_d     = stage_q;
    stg_ovf_d   = stg_ovf_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_ovf_d   = res_ovf_q;
    samp        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          cnt_d     = CW'(1);
          gcnt_d    = '0;
          line1_d   = in_a[0];
          line2_d   = in_b[0];
          sh_a_d    = in_a >> 1;
          sh_b_d    = in_b >> 1;
          stage_d   = '0;
          stg_ovf_d = 1'b0;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        samp  = (cnt_q > L_C);
        if (cnt_q < W_C) begin
          line1_d = sh_a_q[0];
          line2_d = sh_b_q[0];
          sh_a_d  = sh_a_q >> 1;
          sh_b_d  = sh_b_q >> 1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        samp = 1'b1;
        if (cnt_q == END_C) begin
          state_d     = (GAP == 0) ? IDLE : GAP_S;
          gcnt_d      = GW'(1);
          res_valid_d = 1'b1;
          res_data_d  = {rx_outp, stage_q[WIDTH-1:1]};
          res_ovf_d   = stg_ovf_q | rx_overflw;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP_S: begin
        if (gcnt_q == G_C) begin
          state_d = IDLE;
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (samp) begin
      stage_d   = {rx_outp, stage_q[WIDTH-1:1]};
      stg_ovf_d = stg_ovf_q | rx_overflw;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      line1_q     <= 1'b0;
      line2_q     <= 1'b0;
      stage_q     <= '0;
      stg_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      line1_q     <= line1_d;
      line2_q     <= line2_d;
      stage_q     <= stage_d;
      stg_ovf_q   <= stg_ovf_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_ovf_q   <= res_ovf_d;
    end
  end

  assign line1     = line1_q;
  assign line2     = line2_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_ovf   = res_ovf_q;
  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

endmodule
